// File: rtl/ds_sinc3_decimator.sv
// rtl/ds_sinc3_decimator.sv - sinc3 CIC decimator turning a 1-bit delta-sigma stream into 16-bit PCM
module ds_sinc3_decimator #(
   parameter int LOG2_R = 6
) (
   input  logic        clk50m,
   input  logic        rst,
   input  logic        din,
   input  logic        din_valid,
   output logic [15:0] dout,
   output logic        dout_valid
);

   localparam int W  = 3 * LOG2_R + 1;
   localparam int SH = 3 * LOG2_R - 16;
   localparam logic [W-1:0] C3_FULL = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0]      i1, i2, i3;
   logic [W-1:0]      d1, d2, d3;
   logic [W-1:0]      i1_n, i2_n, i3_n;
   logic [W-1:0]      c1, c2, c3;
   logic [LOG2_R-1:0] dec_cnt;
   logic [1:0]        settle;
   logic              comb_pend;
   logic [15:0]       scaled;

   always_comb begin
      i1_n = i1 + W'(din);
      i2_n = i2 + i1_n;
      i3_n = i3 + i2_n;
      // comb sees I3 as it stood after the event sample, before this edge's sample
      c1 = i3 - d1;
      c2 = c1 - d2;
      c3 = c2 - d3;
      scaled = (c3 == C3_FULL) ? 16'hFFFF : c3[W-2:SH];
   end

   always_ff @(posedge clk50m) begin
      if (rst) begin
         i1         <= '0;
         i2         <= '0;
         i3         <= '0;
         d1         <= '0;
         d2         <= '0;
         d3         <= '0;
         dec_cnt    <= '0;
         settle     <= '0;
         comb_pend  <= 1'b0;
         dout       <= 16'h0000;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         comb_pend  <= din_valid && (dec_cnt == '1);
         if (din_valid) begin
            i1      <= i1_n;
            i2      <= i2_n;
            i3      <= i3_n;
            dec_cnt <= dec_cnt + LOG2_R'(1);
         end
         if (comb_pend) begin
            d1 <= i3;
            d2 <= c1;
            d3 <= c2;
            // the first two frames only prime the comb delays
            if (settle == 2'd2) begin
               dout       <= scaled;
               dout_valid <= 1'b1;
            end else begin
               settle <= settle + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ds_sinc3_decimator.sv
// tb/tb_ds_sinc3_decimator.sv - directed self-checking bench for ds_sinc3_decimator (R = 64)
module tb_ds_sinc3_decimator;

   logic        clk50m = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic [15:0] dout;
   logic        dout_valid;

   always #10 clk50m = ~clk50m;

   ds_sinc3_decimator #(.LOG2_R(6)) dut (
      .clk50m    (clk50m),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .dout      (dout),
      .dout_valid(dout_valid)
   );

   typedef struct {
      logic [7:0]  pat;
      int          plen;
      logic [15:0] exp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          acc_cnt = 0;
   bit          ev_pending = 0;
   bit          ev_care = 0;
   bit          dout_known = 1;
   int          skip = 0;
   logic [15:0] ev_val = 16'h0;
   logic [15:0] exp_dout = 16'h0;
   logic [15:0] cur_exp = 16'h0;
   longint      cyc = 0;
   longint      last_strobe = 0;
   bit          seen_strobe = 0;
   int          period = 0;
   logic [15:0] mod_acc = 16'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // one clock with given inputs; a strobe is due one edge after an accepted sample that completes a frame from the third on
   task automatic step(input logic d, input logic v);
      bit exp_v;
      din = d;
      din_valid = v;
      @(posedge clk50m);
      #1;
      cyc++;
      exp_v = ev_pending;
      if (exp_v) begin
         if (ev_care) begin
            exp_dout = ev_val;
            dout_known = 1;
         end else begin
            dout_known = 0;
         end
      end
      ev_pending = 0;
      if (v) begin
         acc_cnt++;
         if (acc_cnt % 64 == 0 && acc_cnt >= 192) begin
            ev_pending = 1;
            ev_val = cur_exp;
            ev_care = (skip == 0);
            if (skip > 0) skip--;
         end
      end
      check("dout_valid", 32'(dout_valid), 32'(exp_v));
      if (dout_known) check("dout", 32'(dout), 32'(exp_dout));
      if (dout_valid) begin
         if (seen_strobe) period = int'(cyc - last_strobe);
         last_strobe = cyc;
         seen_strobe = 1;
      end
   endtask

   task automatic do_reset(input logic v);
      rst = 1'b1;
      din = 1'b1;
      din_valid = v;
      @(posedge clk50m);
      #1;
      cyc++;
      rst = 1'b0;
      acc_cnt = 0;
      ev_pending = 0;
      exp_dout = 16'h0;
      dout_known = 1;
      skip = 0;
      seen_strobe = 0;
      period = 0;
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_dout_valid", 32'(dout_valid), 32'h0);
   endtask

   function automatic logic pat_bit(input logic [7:0] pat, input int plen, input int i);
      return pat[plen - 1 - (i % plen)];
   endfunction

   function automatic logic mod_bit(input logic [15:0] val);
      logic [16:0] s;
      s = {1'b0, mod_acc} + {1'b0, val};
      mod_acc = s[15:0];
      return s[16];
   endfunction

   vec_t vecs[7];

   initial begin
      vecs[0] = '{pat: 8'h00, plen: 1, exp: 16'h0000};
      vecs[1] = '{pat: 8'h01, plen: 1, exp: 16'hFFFF};
      vecs[2] = '{pat: 8'h02, plen: 2, exp: 16'h8000};
      vecs[3] = '{pat: 8'h08, plen: 4, exp: 16'h4000};
      vecs[4] = '{pat: 8'h0C, plen: 4, exp: 16'h8000};
      vecs[5] = '{pat: 8'h0E, plen: 4, exp: 16'hC000};
      vecs[6] = '{pat: 8'h80, plen: 8, exp: 16'h2000};

      for (int v = 0; v < 7; v++) begin
         do_reset(1'b0);
         cur_exp = vecs[v].exp;
         for (int i = 0; i < 320; i++) step(pat_bit(vecs[v].pat, vecs[v].plen, i), 1'b1);
         check("strobe_period", 32'(period), 32'd64);
      end

      // din_valid toggling, invalid cycles carry din=1 which must be ignored
      do_reset(1'b0);
      cur_exp = 16'h8000;
      for (int i = 0; i < 320; i++) begin
         step(1'b1, 1'b0);
         step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      end
      check("gap_period", 32'(period), 32'd128);

      // first-order delta-sigma source stepping 8000 -> 4000 on a frame boundary
      do_reset(1'b0);
      mod_acc = 16'h0;
      cur_exp = 16'h8000;
      for (int i = 0; i < 320; i++) step(mod_bit(16'h8000), 1'b1);
      cur_exp = 16'h4000;
      skip = 2;
      for (int i = 0; i < 384; i++) step(mod_bit(16'h4000), 1'b1);

      // reset mid-frame at accepted sample 100, with din_valid high during reset
      do_reset(1'b0);
      cur_exp = 16'hFFFF;
      while (acc_cnt < 100) step(1'b1, 1'b1);
      do_reset(1'b1);
      for (int i = 0; i < 260; i++) step(1'b1, 1'b1);

      // reset on the edge right after a settled decimation event cancels the pending strobe
      do_reset(1'b0);
      cur_exp = 16'hFFFF;
      while (acc_cnt < 256) step(1'b1, 1'b1);
      check("event_pending_before_rst", 32'(ev_pending), 32'd1);
      do_reset(1'b1);
      for (int i = 0; i < 260; i++) step(1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
